// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy three-coin change dispenser with a valid/ready coin output
module change_dispenser #(
  parameter int TOTAL_BITS = 31,
  parameter int COIN0      = 100,
  parameter int COIN1      = 500,
  parameter int COIN2      = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic [TOTAL_BITS-1:0] i_return_total,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [2:0]            o_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [TOTAL_BITS-1:0] o_remaining
);

  localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0);
  localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1);
  localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2);

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

  state_t                state_q, state_d;
  logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
  logic                  error_q, error_d;
  logic [2:0]            coin_sel;
  logic [TOTAL_BITS-1:0] coin_val;
  logic [TOTAL_BITS-1:0] rem_after;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      error_q     <= error_d;
    end
  end

  // Largest coin not exceeding the registered amount, so the subtraction cannot wrap.
  always_comb begin
    coin_sel = 3'b000;
    coin_val = '0;
    if (remaining_q >= C2) begin
      coin_sel = 3'b100;
      coin_val = C2;
    end else if (remaining_q >= C1) begin
      coin_sel = 3'b010;
      coin_val = C1;
    end else if (remaining_q >= C0) begin
      coin_sel = 3'b001;
      coin_val = C0;
    end
  end

  assign rem_after = remaining_q - coin_val;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    error_d      = error_q;
    o_coin_valid = 1'b0;
    o_coin       = 3'b000;
    o_done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          remaining_d = i_return_total;
          error_d     = 1'b0;
          if (i_return_total >= C0) begin
            state_d = DISPENSE;
          end else begin
            // Any non-zero residue below the smallest coin is undispensable.
            state_d = DONE;
            error_d = (i_return_total != '0);
          end
        end
      end
      DISPENSE: begin
        o_coin_valid = 1'b1;
        o_coin       = coin_sel;
        if (i_coin_ready) begin
          remaining_d = rem_after;
          if (rem_after < C0) begin
            state_d = DONE;
            error_d = (rem_after != '0);
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy      = (state_q != IDLE);
  assign o_error     = error_q;
  assign o_remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed vector bench for change_dispenser
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_load = 1'b0;
  logic [30:0] i_return_total = '0;
  logic        i_coin_ready = 1'b0;
  logic        o_coin_valid;
  logic [2:0]  o_coin;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [30:0] o_remaining;

  int errors = 0;
  int checks = 0;

  change_dispenser dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_load         (i_load),
    .i_return_total (i_return_total),
    .i_coin_ready   (i_coin_ready),
    .o_coin_valid   (o_coin_valid),
    .o_coin         (o_coin),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_remaining    (o_remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] amt;
    int          n;
    logic [23:0] seq;
    logic [30:0] rem;
    logic        err;
  } vec_t;

  vec_t       vecs [6];
  logic [2:0] coins [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [30:0] amt);
    @(negedge clk);
    i_load = 1'b1;
    i_return_total = amt;
    @(posedge clk);
    #1 i_load = 1'b0;
  endtask

  initial begin
    int got;
    int done_c;

    vecs[0] = '{amt: 31'd1600, n: 3, seq: {15'b0, 3'b001, 3'b010, 3'b100}, rem: 31'd0,  err: 1'b0};
    vecs[1] = '{amt: 31'd250,  n: 2, seq: {18'b0, 3'b001, 3'b001},          rem: 31'd50, err: 1'b1};
    vecs[2] = '{amt: 31'd0,    n: 0, seq: 24'b0,                            rem: 31'd0,  err: 1'b0};
    vecs[3] = '{amt: 31'd100,  n: 1, seq: {21'b0, 3'b001},                  rem: 31'd0,  err: 1'b0};
    vecs[4] = '{amt: 31'd3700, n: 6,
                seq: {6'b0, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100}, rem: 31'd0, err: 1'b0};
    vecs[5] = '{amt: 31'd1099, n: 1, seq: {21'b0, 3'b100},                  rem: 31'd99, err: 1'b1};

    #12;
    chk("rst_valid", {31'b0, o_coin_valid}, 0);
    chk("rst_coin",  {29'b0, o_coin}, 0);
    chk("rst_busy",  {31'b0, o_busy}, 0);
    chk("rst_done",  {31'b0, o_done}, 0);
    chk("rst_error", {31'b0, o_error}, 0);
    chk("rst_rem",   {1'b0, o_remaining}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    i_coin_ready = 1'b1;
    foreach (vecs[v]) begin
      load(vecs[v].amt);
      got = 0;
      done_c = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (o_coin_valid) begin
          if (got < 8) coins[got] = o_coin;
          got++;
        end
        if (o_done) begin
          done_c = c;
          break;
        end
      end
      chk($sformatf("v%0d_done_cycle", v), done_c, vecs[v].n + 1);
      chk($sformatf("v%0d_ncoins", v), got, vecs[v].n);
      for (int i = 0; i < vecs[v].n && i < 8; i++)
        chk($sformatf("v%0d_coin%0d", v, i), {29'b0, coins[i]}, {29'b0, vecs[v].seq[3*i +: 3]});
      chk($sformatf("v%0d_rem", v), {1'b0, o_remaining}, {1'b0, vecs[v].rem});
      chk($sformatf("v%0d_err", v), {31'b0, o_error}, {31'b0, vecs[v].err});
      @(negedge clk);
      chk($sformatf("v%0d_idle", v), {30'b0, o_busy, o_done}, 0);
    end

    // Stalled coin output: the coin must hold while ready is low.
    i_coin_ready = 1'b0;
    load(31'd1000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_coin", c), {28'b0, o_coin_valid, o_coin}, {28'b0, 4'b1100});
      chk($sformatf("stall%0d_rem", c), {1'b0, o_remaining}, 1000);
      if (c == 4) i_coin_ready = 1'b1;
    end
    @(negedge clk);
    chk("stall_done", {30'b0, o_done, o_coin_valid}, 2);
    chk("stall_rem", {1'b0, o_remaining}, 0);
    chk("stall_err", {31'b0, o_error}, 0);

    // A load while busy is ignored.
    load(31'd2000);
    got = 0;
    done_c = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_coin_valid) begin
        chk($sformatf("busy_coin%0d", got), {29'b0, o_coin}, 4);
        got++;
      end
      if (o_done) begin
        done_c = c;
        break;
      end
      if (c == 1) begin
        i_load = 1'b1;
        i_return_total = 31'd3000;
        @(posedge clk);
        #1 i_load = 1'b0;
      end
    end
    chk("busy_ncoins", got, 2);
    chk("busy_done_cycle", done_c, 3);
    chk("busy_rem", {1'b0, o_remaining}, 0);

    // Reset in the middle of dispensing.
    load(31'd1500);
    @(negedge clk);
    chk("mid_coin1", {29'b0, o_coin}, 4);
    @(negedge clk);
    chk("mid_coin2", {29'b0, o_coin}, 2);
    chk("mid_rem2", {1'b0, o_remaining}, 500);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {28'b0, o_coin_valid, o_coin}, 0);
    chk("mid_rst_rem", {1'b0, o_remaining}, 0);
    chk("mid_rst_flags", {29'b0, o_busy, o_done, o_error}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid_nodone%0d", c), {31'b0, o_done}, 0);
    end
    reset_n = 1'b1;
    load(31'd100);
    @(negedge clk);
    chk("post_coin", {28'b0, o_coin_valid, o_coin}, {28'b0, 4'b1001});
    @(negedge clk);
    chk("post_done", {30'b0, o_done, o_coin_valid}, 2);
    chk("post_rem", {1'b0, o_remaining}, 0);
    chk("post_err", {31'b0, o_error}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL take parameter TOTAL_BITS, default 31, which sets the width of all amount buses.
REQ-002 The block SHALL take parameter COIN0, default 100, the smallest coin value.
REQ-003 The block SHALL take parameter COIN1, default 500, the middle coin value.
REQ-004 The block SHALL take parameter COIN2, default 1000, the largest coin value; COIN0 < COIN1 < COIN2 is required.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_load, input, 1 bit: a one-cycle request to start dispensing i_return_total.
REQ-008 The block SHALL have port i_return_total, input, TOTAL_BITS: the change amount, sampled when a load is accepted.
REQ-009 The block SHALL have port i_coin_ready, input, 1 bit: the coin-output mechanism accepts the presented coin.
REQ-010 The block SHALL have port o_coin_valid, output, 1 bit: a coin is being presented.
REQ-011 The block SHALL have port o_coin, output, 3 bits: the presented coin, one-hot; bit0 = COIN0, bit1 = COIN1, bit2 = COIN2.
REQ-012 The block SHALL have port o_busy, output, 1 bit: the block is not IDLE.
REQ-013 The block SHALL have port o_done, output, 1 bit: a one-cycle completion pulse.
REQ-014 The block SHALL have port o_error, output, 1 bit: the last amount was not fully dispensable.
REQ-015 The block SHALL have port o_remaining, output, TOTAL_BITS: the registered amount not yet dispensed.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, DISPENSE and DONE; o_busy = (state != IDLE).
REQ-017 In IDLE with i_load=1, on the clock edge:
  - remaining <= i_return_total and o_error <= 0;
  - next state is DISPENSE if i_return_total >= COIN0, otherwise DONE.
REQ-018 i_load SHALL be ignored while o_busy=1; no state, remaining or error change results.
REQ-019 In DISPENSE, o_coin_valid SHALL be 1, and o_coin SHALL be the largest coin value <= remaining, decoded from registered state only (no combinational path from inputs to outputs).
REQ-020 While o_coin_valid=1 and i_coin_ready=0, o_coin and o_remaining SHALL hold stable.
REQ-021 A handshake (o_coin_valid & i_coin_ready) at an edge SHALL subtract the coin value from remaining.
  - The next state is DONE if the new remaining < COIN0, otherwise DISPENSE.
  - Exactly one coin transfers per handshake, one coin per cycle maximum.
REQ-022 Subtraction SHALL never underflow: the coin selection guarantees value <= remaining.
REQ-023 In DONE, o_done SHALL be 1 for exactly one cycle, o_coin_valid SHALL be 0, and the next state is IDLE.
REQ-024 On entry to DONE, if remaining != 0, o_error SHALL be set to 1 and held until the next accepted load or reset; the residue stays visible on o_remaining.
REQ-025 Outside DISPENSE, o_coin_valid=0 and o_coin=3'b000.
REQ-026 Latency:
  - load accepted at edge k gives the first coin valid in cycle k+1;
  - with i_coin_ready held at 1, N coins complete at edges k+1..k+N and o_done is high in cycle k+N+1.
REQ-027 With the default parameters, a load with i_return_total < 100 SHALL produce no coins and o_done in cycle k+1.

Reset
REQ-028 When reset_n=0, asynchronously and regardless of clk:
  - state = IDLE and remaining = 0;
  - o_coin_valid = 0, o_coin = 0;
  - o_done = 0, o_error = 0, o_busy = 0.
REQ-029 A reset asserted mid-DISPENSE SHALL drop o_coin_valid immediately, discard the remaining amount, and cause no o_done pulse.
REQ-030 After reset_n deasserts, the first i_load SHALL be accepted at the next rising edge.

Verification
REQ-031 The bench SHALL cover: load 1600, i_coin_ready=1 -> coins COIN2, COIN1, COIN0 in consecutive cycles, o_done one cycle later, o_remaining=0, o_error=0.
REQ-032 The bench SHALL cover: load 250, ready=1 -> two COIN0 coins, o_done, o_error=1, o_remaining=50.
REQ-033 The bench SHALL cover: load 1000, i_coin_ready=0 for 3 cycles then 1 -> o_coin=3'b100 held stable for 4 cycles, a single transfer, then o_done.
REQ-034 The bench SHALL cover: load 0 -> no o_coin_valid, o_done in the next cycle, o_error=0.
REQ-035 The bench SHALL cover: load 2000, then a second i_load=3000 while busy -> it is ignored; exactly two COIN2 coins are dispensed.
REQ-036 The bench SHALL cover: load 1500, reset_n pulsed low after the first coin -> outputs reset immediately, no o_done, and a fresh load 100 then dispenses one COIN0.
